// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB/FU constants for the completion arbiter and its users.
// Column bases follow the fu_result concatenation {branch, alu, mult, ldst}.
package sys_defs;

    localparam int N             = 2;
    localparam int NUM_FU_ALU    = 3;
    localparam int NUM_FU_MULT   = 2;
    localparam int NUM_FU_BRANCH = 1;
    localparam int NUM_FU_LDST   = 1;
    localparam int NUM_FU_TOTAL  = NUM_FU_ALU + NUM_FU_MULT
                                 + NUM_FU_BRANCH + NUM_FU_LDST;
    localparam int STARVE_LIMIT  = 4;

    localparam int FU_COL_LDST   = 0;
    localparam int FU_COL_MULT   = FU_COL_LDST + NUM_FU_LDST;
    localparam int FU_COL_ALU    = FU_COL_MULT + NUM_FU_MULT;
    localparam int FU_COL_BRANCH = FU_COL_ALU + NUM_FU_ALU;

    typedef logic [N-1:0][NUM_FU_TOTAL-1:0] CDB_GNT_BUS;

endpackage

// File: rtl/cdb_arbiter_rr_slot_picker.sv
// Round-robin picker: up to K one-hot picks from req, starting at ptr.
// next_ptr is one past the last pick in rotation order.
module rr_slot_picker #(
    parameter int W  = 3,
    parameter int K  = 2,
    parameter int PW = (W > 1) ? $clog2(W) : 1,
    parameter int CW = $clog2(K + 1)
) (
    input  logic [W-1:0]        req,
    input  logic [PW-1:0]       ptr,
    input  logic [CW-1:0]       free_slots,
    output logic [K-1:0][W-1:0] picks,
    output logic [CW-1:0]       pick_cnt,
    output logic [PW-1:0]       next_ptr
);

    always_comb begin
        picks    = '0;
        pick_cnt = '0;
        next_ptr = ptr;
        for (int o = 0; o < W; o++) begin
            for (int b = 0; b < W; b++) begin
                if (b == (int'(ptr) + o) % W && req[b]
                    && pick_cnt < free_slots) begin
                    for (int k = 0; k < K; k++) begin
                        if (k == int'(pick_cnt)) picks[k][b] = 1'b1;
                    end
                    pick_cnt = pick_cnt + CW'(1);
                    next_ptr = PW'((b + 1) % W);
                end
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB completion arbiter: fixed priority for single-cycle FUs, round-robin
// with starvation tracking for the result-holding mult/ldst pool.
module cdb_arbiter #(
    parameter int N             = sys_defs::N,
    parameter int NUM_FU_ALU    = sys_defs::NUM_FU_ALU,
    parameter int NUM_FU_MULT   = sys_defs::NUM_FU_MULT,
    parameter int NUM_FU_BRANCH = sys_defs::NUM_FU_BRANCH,
    parameter int NUM_FU_LDST   = sys_defs::NUM_FU_LDST,
    parameter int NUM_FU_TOTAL  = NUM_FU_ALU + NUM_FU_MULT
                                + NUM_FU_BRANCH + NUM_FU_LDST,
    parameter int STARVE_LIMIT  = sys_defs::STARVE_LIMIT
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic [NUM_FU_ALU-1:0]               alu_req,
    input  logic [NUM_FU_BRANCH-1:0]            branch_req,
    input  logic [NUM_FU_MULT-1:0]              mult_req,
    input  logic [NUM_FU_LDST-1:0]              ldst_req,
    output logic [N-1:0][NUM_FU_TOTAL-1:0]      complete_gnt_bus,
    output logic [NUM_FU_MULT-1:0]              mult_cdb_en,
    output logic [NUM_FU_LDST-1:0]              ldst_cdb_en,
    output logic                                cdb_reserve,
    output logic                                overflow_err,
    output logic [$clog2(N+1)-1:0]              grant_count
);

    localparam int POOL    = NUM_FU_MULT + NUM_FU_LDST;
    localparam int PW      = (POOL > 1) ? $clog2(POOL) : 1;
    localparam int CW      = $clog2(N + 1);
    localparam int SW      = $clog2(STARVE_LIMIT + 1);
    localparam int COL_LD  = 0;
    localparam int COL_MU  = COL_LD + NUM_FU_LDST;
    localparam int COL_ALU = COL_MU + NUM_FU_MULT;
    localparam int COL_BR  = COL_ALU + NUM_FU_ALU;

    logic [N-1:0][NUM_FU_TOTAL-1:0] sc_gnt;
    logic [N-1:0][NUM_FU_TOTAL-1:0] gnt;
    logic [CW-1:0]                  sc_used;
    logic [CW-1:0]                  free_slots;
    logic                           sc_over;

    logic [POOL-1:0]                pool_req;
    logic [POOL-1:0]                pool_gnt;
    logic [N-1:0][POOL-1:0]         picks;
    logic [CW-1:0]                  pick_cnt;
    logic [PW-1:0]                  rr_ptr;
    logic [PW-1:0]                  rr_next;

    logic [POOL-1:0][SW-1:0]        starve;
    logic [POOL-1:0][SW-1:0]        starve_nxt;
    logic                           reserve_nxt;

    assign pool_req = {ldst_req, mult_req};

    // Branch then ALU, lowest index first; requests past N only flag overflow.
    always_comb begin
        sc_gnt  = '0;
        sc_used = '0;
        sc_over = 1'b0;
        for (int b = 0; b < NUM_FU_BRANCH; b++) begin
            if (branch_req[b]) begin
                if (sc_used < CW'(N)) begin
                    for (int r = 0; r < N; r++) begin
                        if (r == int'(sc_used)) sc_gnt[r][COL_BR+b] = 1'b1;
                    end
                    sc_used = sc_used + CW'(1);
                end else begin
                    sc_over = 1'b1;
                end
            end
        end
        for (int a = 0; a < NUM_FU_ALU; a++) begin
            if (alu_req[a]) begin
                if (sc_used < CW'(N)) begin
                    for (int r = 0; r < N; r++) begin
                        if (r == int'(sc_used)) sc_gnt[r][COL_ALU+a] = 1'b1;
                    end
                    sc_used = sc_used + CW'(1);
                end else begin
                    sc_over = 1'b1;
                end
            end
        end
    end

    assign free_slots = CW'(N) - sc_used;

    rr_slot_picker #(
        .W  (POOL),
        .K  (N),
        .PW (PW),
        .CW (CW)
    ) u_picker (
        .req        (pool_req),
        .ptr        (rr_ptr),
        .free_slots (free_slots),
        .picks      (picks),
        .pick_cnt   (pick_cnt),
        .next_ptr   (rr_next)
    );

    // Pool picks stack directly above the single-cycle rows.
    always_comb begin
        gnt = sc_gnt;
        for (int j = 0; j < N; j++) begin
            for (int r = 0; r < N; r++) begin
                if (j < int'(pick_cnt) && r == int'(sc_used) + j) begin
                    for (int m = 0; m < NUM_FU_MULT; m++) begin
                        if (picks[j][m]) gnt[r][COL_MU+m] = 1'b1;
                    end
                    for (int l = 0; l < NUM_FU_LDST; l++) begin
                        if (picks[j][NUM_FU_MULT+l]) gnt[r][COL_LD+l] = 1'b1;
                    end
                end
            end
        end
        if (reset) gnt = '0;
    end

    always_comb begin
        mult_cdb_en = '0;
        ldst_cdb_en = '0;
        for (int r = 0; r < N; r++) begin
            mult_cdb_en = mult_cdb_en | gnt[r][COL_MU +: NUM_FU_MULT];
            ldst_cdb_en = ldst_cdb_en | gnt[r][COL_LD +: NUM_FU_LDST];
        end
    end

    assign complete_gnt_bus = gnt;
    assign grant_count      = reset ? '0 : sc_used + pick_cnt;

    always_comb begin
        pool_gnt = '0;
        for (int j = 0; j < N; j++) pool_gnt = pool_gnt | picks[j];
    end

    always_comb begin
        starve_nxt  = starve;
        reserve_nxt = 1'b0;
        for (int p = 0; p < POOL; p++) begin
            if (!pool_req[p] || pool_gnt[p]) begin
                starve_nxt[p] = '0;
            end else if (starve[p] != SW'(STARVE_LIMIT)) begin
                starve_nxt[p] = starve[p] + SW'(1);
            end
            if (starve_nxt[p] == SW'(STARVE_LIMIT)) reserve_nxt = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_ptr       <= '0;
            starve       <= '0;
            cdb_reserve  <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            if (pick_cnt != '0) rr_ptr <= rr_next;
            starve       <= starve_nxt;
            cdb_reserve  <= reserve_nxt;
            overflow_err <= overflow_err | sc_over;
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed vectors, multi-cycle sequences and random invariant checks
// for the CDB completion arbiter.
module tb_cdb_arbiter;

    logic                clock;
    logic                reset;
    logic [2:0]          alu_req;
    logic [0:0]          branch_req;
    logic [1:0]          mult_req;
    logic [0:0]          ldst_req;
    sys_defs::CDB_GNT_BUS gnt;
    logic [1:0]          mult_cdb_en;
    logic [0:0]          ldst_cdb_en;
    logic                cdb_reserve;
    logic                overflow_err;
    logic [1:0]          grant_count;

    int checks = 0;
    int errors = 0;

    cdb_arbiter dut (
        .clock            (clock),
        .reset            (reset),
        .alu_req          (alu_req),
        .branch_req       (branch_req),
        .mult_req         (mult_req),
        .ldst_req         (ldst_req),
        .complete_gnt_bus (gnt),
        .mult_cdb_en      (mult_cdb_en),
        .ldst_cdb_en      (ldst_cdb_en),
        .cdb_reserve      (cdb_reserve),
        .overflow_err     (overflow_err),
        .grant_count      (grant_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  alu;
        logic        br;
        logic [1:0]  mult;
        logic        ldst;
        logic [13:0] g;
        logic [1:0]  men;
        logic        len;
        logic [1:0]  cnt;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] a, input logic b,
                         input logic [1:0] m, input logic l);
        alu_req    = a;
        branch_req = b;
        mult_req   = m;
        ldst_req   = l;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(3'b000, 1'b0, 2'b00, 1'b0);
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // columns: 0 ldst0, 1 mult0, 2 mult1, 3-5 alu0-2, 6 branch0
        tbl[0] = '{3'b001, 1'b1, 2'b00, 1'b0, {7'h08, 7'h40}, 2'b00, 1'b0, 2'd2};
        tbl[1] = '{3'b000, 1'b0, 2'b00, 1'b0, {7'h00, 7'h00}, 2'b00, 1'b0, 2'd0};
        tbl[2] = '{3'b100, 1'b0, 2'b00, 1'b0, {7'h00, 7'h20}, 2'b00, 1'b0, 2'd1};
        tbl[3] = '{3'b000, 1'b0, 2'b01, 1'b0, {7'h00, 7'h02}, 2'b01, 1'b0, 2'd1};
        tbl[4] = '{3'b000, 1'b1, 2'b00, 1'b1, {7'h01, 7'h40}, 2'b00, 1'b1, 2'd2};
        tbl[5] = '{3'b010, 1'b0, 2'b11, 1'b1, {7'h02, 7'h10}, 2'b01, 1'b0, 2'd2};
        tbl[6] = '{3'b000, 1'b0, 2'b10, 1'b1, {7'h01, 7'h04}, 2'b10, 1'b1, 2'd2};
        tbl[7] = '{3'b011, 1'b0, 2'b01, 1'b0, {7'h10, 7'h08}, 2'b00, 1'b0, 2'd2};
        tbl[8] = '{3'b111, 1'b0, 2'b00, 1'b0, {7'h10, 7'h08}, 2'b00, 1'b0, 2'd2};

        reset = 1'b1;
        drive(3'b000, 1'b0, 2'b00, 1'b0);
        tick();
        tick();
        chk("reset_gnt", gnt, 0);
        chk("reset_count", grant_count, 0);
        chk("reset_en", {mult_cdb_en, ldst_cdb_en}, 0);
        reset = 1'b0;
        #1;
        chk("reset_reserve", cdb_reserve, 0);
        chk("reset_overflow", overflow_err, 0);

        for (int i = 0; i < 9; i++) begin
            do_reset();
            drive(tbl[i].alu, tbl[i].br, tbl[i].mult, tbl[i].ldst);
            #1;
            chk($sformatf("vec%0d_gnt", i), gnt, tbl[i].g);
            chk($sformatf("vec%0d_mult_en", i), mult_cdb_en, tbl[i].men);
            chk($sformatf("vec%0d_ldst_en", i), ldst_cdb_en, tbl[i].len);
            chk($sformatf("vec%0d_count", i), grant_count, tbl[i].cnt);
        end

        // Round-robin rotation and wrap over {ldst0, mult1, mult0}
        do_reset();
        drive(3'b000, 1'b0, 2'b11, 1'b1);
        #1;
        chk("rr_c1_gnt", gnt, {7'h04, 7'h02});
        chk("rr_c1_en", {mult_cdb_en, ldst_cdb_en}, 3'b110);
        tick();
        chk("rr_c2_gnt", gnt, {7'h02, 7'h01});
        chk("rr_c2_en", {mult_cdb_en, ldst_cdb_en}, 3'b011);
        tick();
        chk("rr_c3_gnt", gnt, {7'h01, 7'h04});
        chk("rr_c3_en", {mult_cdb_en, ldst_cdb_en}, 3'b101);
        tick();
        chk("rr_c4_gnt", gnt, {7'h04, 7'h02});
        chk("rr_reserve", cdb_reserve, 0);

        // Starvation of mult0 behind two ALUs
        do_reset();
        drive(3'b011, 1'b0, 2'b01, 1'b0);
        #1;
        chk("starve_c0_reserve", cdb_reserve, 0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("starve_c%0d_reserve", i), cdb_reserve, (i == 4));
            chk($sformatf("starve_c%0d_men", i), mult_cdb_en, 0);
        end
        drive(3'b001, 1'b0, 2'b01, 1'b0);
        #1;
        chk("starve_grant_gnt", gnt, {7'h02, 7'h08});
        chk("starve_grant_men", mult_cdb_en, 2'b01);
        chk("starve_grant_reserve", cdb_reserve, 1);
        tick();
        drive(3'b000, 1'b0, 2'b00, 1'b0);
        #1;
        chk("starve_release_reserve", cdb_reserve, 0);

        // Overflow: three ALUs, sticky flag
        do_reset();
        drive(3'b111, 1'b0, 2'b00, 1'b0);
        #1;
        chk("ovf_gnt", gnt, {7'h10, 7'h08});
        chk("ovf_pre_flag", overflow_err, 0);
        tick();
        drive(3'b000, 1'b0, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("ovf_idle%0d_flag", i), overflow_err, 1);
            chk($sformatf("ovf_idle%0d_gnt", i), gnt, 0);
            tick();
        end

        // Reset mid-operation with moved pointer, live counters, overflow
        do_reset();
        drive(3'b000, 1'b0, 2'b10, 1'b0);
        tick();
        drive(3'b011, 1'b0, 2'b01, 1'b0);
        tick();
        tick();
        drive(3'b111, 1'b0, 2'b01, 1'b0);
        tick();
        chk("mid_pre_overflow", overflow_err, 1);
        reset = 1'b1;
        #1;
        chk("mid_reset_gnt", gnt, 0);
        chk("mid_reset_count", grant_count, 0);
        chk("mid_reset_en", {mult_cdb_en, ldst_cdb_en}, 0);
        tick();
        reset = 1'b0;
        drive(3'b000, 1'b0, 2'b11, 1'b1);
        #1;
        chk("mid_after_gnt", gnt, {7'h04, 7'h02});
        chk("mid_after_reserve", cdb_reserve, 0);
        chk("mid_after_overflow", overflow_err, 0);
        tick();
        drive(3'b011, 1'b0, 2'b01, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk($sformatf("mid_starve%0d_reserve", i), cdb_reserve, (i == 4));
        end

        // Random invariants
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            logic [6:0] reqv;
            logic [6:0] any;
            int nreq;
            int nsc;
            int exp_cnt;
            int exp_sc;
            logic ok;
            drive(3'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            #1;
            reqv    = {branch_req, alu_req, mult_req, ldst_req};
            any     = gnt[0] | gnt[1];
            nreq    = $countones(reqv);
            nsc     = $countones({branch_req, alu_req});
            exp_cnt = (nreq < 2) ? nreq : 2;
            exp_sc  = (nsc < 2) ? nsc : 2;
            ok = 1'b1;
            if ((gnt[0] & gnt[1]) != 7'h00) ok = 1'b0;
            if ((any & ~reqv) != 7'h00) ok = 1'b0;
            if (!$onehot0(gnt[0]) || !$onehot0(gnt[1])) ok = 1'b0;
            if (gnt[0] == 7'h00 && gnt[1] != 7'h00) ok = 1'b0;
            if ($countones(any & 7'h78) != exp_sc) ok = 1'b0;
            if (mult_cdb_en != any[2:1] || ldst_cdb_en != any[0]) ok = 1'b0;
            chk($sformatf("rand%0d_legal", c), ok, 1);
            chk($sformatf("rand%0d_count", c), grant_count, exp_cnt);
            chk($sformatf("rand%0d_popcount", c), $countones(gnt), exp_cnt);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Grant side of the completion handshake with the execute stage. Each cycle it takes per-FU completion requests and drives `complete_gnt_bus`, `mult_cdb_en` and `ldst_cdb_en`. The execute stage uses these to steer up to N FU results onto the CDB.
- Single-cycle FUs (branch, ALU) cannot hold a result, so they get absolute priority.
- Multi-cycle FUs (mult, ldst) hold their result until granted. They share the remaining CDB slots round-robin, with starvation detection that asks issue to throttle.

Parameters:
- N, 2, CDB width (completions per cycle)
- NUM_FU_ALU, 3, ALU count
- NUM_FU_MULT, 2, multiplier count
- NUM_FU_BRANCH, 1, branch unit count
- NUM_FU_LDST, 1, load/store unit count
- NUM_FU_TOTAL, sum of the four above, total FU count
- STARVE_LIMIT, 4, waiting cycles before reserve is raised

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous active-high reset
- alu_req  in  NUM_FU_ALU  ALU result valid this cycle
- branch_req  in  NUM_FU_BRANCH  branch result valid this cycle
- mult_req  in  NUM_FU_MULT  multiplier holding result (`mult_cdb_valid`)
- ldst_req  in  NUM_FU_LDST  ldst holding result (`ldst_cdb_valid`)
- complete_gnt_bus  out  N x NUM_FU_TOTAL  row i one-hot: FU driving CDB slot i
- mult_cdb_en  out  NUM_FU_MULT  multiplier result accepted this cycle
- ldst_cdb_en  out  NUM_FU_LDST  ldst result accepted this cycle
- cdb_reserve  out  1  registered; issue must send at most N-1 single-cycle ops next cycle
- overflow_err  out  1  registered, sticky; single-cycle requests exceeded N
- grant_count  out  $clog2(N+1)  number of slots granted this cycle

Behaviour:
- Interface: one clock `clock`; `reset` is synchronous and active-high.
- Column order matches the fu_result concatenation, LSB first: ldst[0..], mult[0..], alu[0..], branch[0..]. That is {branch, alu, mult, ldst}.
- Grants are combinational from current requests and registered state, with zero latency. The execute stage muxes results in the same cycle.
- Slot fill order:
  - First: branch requests, lowest index first.
  - Second: ALU requests, lowest index first.
  - Third: mult/ldst requests in round-robin order, starting at `rr_ptr` over the combined MULT+LDST vector, wrapping around.
- Each FU is granted at most once per cycle. Each row has at most one bit set. Unused rows are all-zero, and rows are filled from row 0 upward with no holes.
- `mult_cdb_en[k]` / `ldst_cdb_en[k]` equals the OR of the corresponding column over all rows. It is never asserted without the matching request.
- `rr_ptr` (registered, reset 0): if any mult/ldst was granted, it moves to one past the last granted index, modulo the pool size. Otherwise it holds.
- Starvation counters, one per mult/ldst FU (reset 0):
  - Increment when requesting and not granted; saturate at STARVE_LIMIT.
  - Clear when granted or when not requesting.
  - `cdb_reserve` is registered: 1 when any counter reaches STARVE_LIMIT this cycle. It deasserts the cycle after that FU is granted.
- Overflow: if branch+ALU requests exceed N, all N slots are still filled by priority order and `overflow_err` sets. It stays set until reset; this is a design-bug indicator for verification.
- Empty case: with no requests, all outputs are 0 and all state holds.
- Reset mid-operation: all state clears next edge. Combinational grants during the reset cycle are forced to 0.
- Reset values: `complete_gnt_bus`=0, enables=0, `cdb_reserve`=0, `overflow_err`=0, `grant_count`=0.

Decomposition:
- Shared package (sys_defs):
  - NUM_FU_* constants
  - FU_COL_* base-index constants for each class
  - N
  - a CDB_GNT_BUS typedef, [N-1:0][NUM_FU_TOTAL-1:0]
- Sub-module `rr_slot_picker`:
  - Parameterised width and max picks.
  - Takes request vector, pointer and free-slot count.
  - Returns up to k one-hot picks in rotation order.
  - Instantiated once for the mult/ldst pool.

Test Plan:
- ALU0 and branch0 request, N=2 -> row0 = branch0 column, row1 = ALU0 column, `grant_count`=2, all enables 0.
- mult0, mult1, ldst0 request for 3 cycles with no ALU/branch, `rr_ptr`=0 -> cycle 1 grants mult0,mult1; cycle 2 grants ldst0,mult0; `rr_ptr` wraps correctly.
- 2 ALUs request every cycle while mult0 waits -> after 4 cycles `cdb_reserve`=1. Issue model drops to 1 ALU, mult0 is granted with `mult_cdb_en`=01, and `cdb_reserve` returns 0 the next cycle.
- 3 ALUs request at once -> ALU0 and ALU1 granted, ALU2 dropped, `overflow_err`=1 and it stays set for the following idle cycles.
- Reset asserted while counters are nonzero and requests are active -> grants 0 that cycle. After release, `rr_ptr`=0, counters 0, `cdb_reserve`=0, `overflow_err`=0.
- Random requests for 10k cycles -> no column is set in two rows, no grant appears without its request, and slots granted = min(N, requests) every cycle.
